reservation_station_nw: RTL
===========================

# reservation_station_nw

Parametrised reservation station with N entries, age-ordered issue, and NUM_CDB parallel wakeup/broadcast ports. It sits between the dispatcher and one ALU functional unit. It accepts renamed instructions through a valid/ready handshake and captures operand values from any CDB port. It issues the oldest fully-ready entry into a registered output stage with valid/ready backpressure, and supports whole-station flush on mispredict.

## Interface
- NUM_ENTRIES, 8: station depth, ≥2, need not be a power of two.
- NUM_CDB, 2: number of wakeup/broadcast ports, ≥1.
- AGE_W, $clog2(NUM_ENTRIES): width of the per-entry age field.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all entries and of the output stage.
- in_valid  in  1  dispatcher offers an instruction.
- in_ready  out  1  equals ~full; a transfer occurs when in_valid && in_ready.
- in_func  in  ALU_FUNC  operation.
- in_t1, in_t2, in_dst  in  ROB_TAG_LEN each  source tags and destination tag.
- in_rdy1, in_rdy2  in  1 each  source value already valid.
- in_v1, in_v2  in  XLEN each  source values, meaningful when the matching in_rdy bit is set.
- cdb_valid  in  NUM_CDB  per-port broadcast valid.
- cdb_tag  in  NUM_CDB×ROB_TAG_LEN  broadcast tags.
- cdb_value  in  NUM_CDB×XLEN  broadcast values.
- out_valid  out  1  output stage holds an issued instruction.
- out_ready  in  1  FU accepts; a transfer occurs when out_valid && out_ready.
- out_func, out_v1, out_v2, out_dst  out  ALU_FUNC / XLEN / XLEN / ROB_TAG_LEN  issued instruction.
- count  out  AGE_W+1  number of valid entries.
- full, empty  out  1 each  count==NUM_ENTRIES, count==0.

## Operation
- Each entry holds: valid, func, t1, t2, dst, rdy1, rdy2, v1, v2, age.
- Wakeup: on every edge, for each valid entry and each port p with cdb_valid[p] && cdb_tag[p]==tN && !rdyN, set rdyN=1 and vN=cdb_value[p]. If several ports match, the lowest-index port wins.
- Load: the transfer writes the lowest-index invalid entry.
  - An operand with in_rdy=0 that matches a CDB port in the same cycle is captured as ready with the CDB value.
  - age = count minus 1 if an issue happens in the same cycle, otherwise count.
- Ready flag per entry: valid && rdy1' && rdy2'.
  - rdyN' is the stored rdyN, ORed with the same-cycle CDB match when RS_BYPASS_EN is defined.
- Select: among ready entries, pick the one with minimum age. Ages of valid entries are unique and form the set 0..count-1, so no tie-break is needed.
- Issue fires when (a ready entry exists) && (!out_valid || out_ready). On firing:
  - The output stage loads the selected entry's fields. Operand values use the bypassed CDB value when the bypass applies.
  - The selected entry is cleared.
  - Every valid entry with age > selected age decrements.
- Output stage:
  - Refills on issue.
  - Clears to out_valid=0 when out_ready && !issue.
  - Otherwise holds all fields stable while out_valid && !out_ready.
- Flush: all entries become invalid, out_valid=0, and any load or issue that cycle is discarded. Flush has priority over every other event.
- Dependent instructions never re-broadcast into themselves; dst is never compared against the entry's own sources.

## Timing
- Reset values: all entries invalid, out_valid=0, out_func=ALU_ADD, out_v1=out_v2=0, out_dst=0, count=0, empty=1, full=0, in_ready=1.
- Load to out_valid: minimum 1 edge. An entry loaded already ready at edge k is selectable in cycle k+1, and out_valid rises after edge k+1.
- CDB to issue:
  - With bypass, an entry woken in cycle j can issue at edge j.
  - Without bypass, it issues no earlier than edge j+1.
- Full and issue in the same cycle: in_ready stays 0. A freed slot is reusable only on the next cycle.
- Backpressure: if out_ready=0 while out_valid=1, no issue occurs and entries keep waking.
- Reset asserted mid-operation clears all state immediately, independent of clk.

## Configuration
- RS_BYPASS_EN defined: same-cycle CDB matches count toward readiness and forward their value into the output stage. This saves one cycle on the dependency chain.
- RS_BYPASS_EN undefined: only stored rdy bits qualify for issue. CDB values are always written into entries first.

## Structure
- In the shared package: ALU_FUNC, XLEN, ROB_TAG_LEN, and the RS_ENTRY_NW struct (parametrised by AGE_W via a localparam in the module, or a package typedef at the default depth).
- One sub-module, rs_age_select: combinational minimum-age finder over ready flags. It returns the selected index and a found flag.

## Test plan
- Basic issue: reset; load ADD with rdy1=rdy2=1, v1=3, v2=4, dst=5 -> out_valid after next edge; out_v1=3, out_v2=4, out_dst=5; count returns to 0 after out_ready.
- Wakeup on two ports: load entries waiting on tags 7 and 9; drive cdb port0 tag 9 = 0x11 and port1 tag 7 = 0x22 in the same cycle -> both entries become ready and issue oldest-first on consecutive cycles with the captured values.
- Age ordering: load A (waiting on tag 2), then B and C (ready) -> B issues, then C. Wake tag 2 -> A issues. Check that ages compact to 0..count-1.
- Full and backpressure: fill NUM_ENTRIES entries with out_ready=0 -> in_ready=0, full=1, output stays stable. Release out_ready -> one issue per cycle, and in_ready returns 1 the cycle after the first issue.
- Load-cycle capture: load with in_rdy1=0, in_t1=4 while cdb tag 4 = 0x55 -> entry stored with rdy1=1, v1=0x55, and never stalls.
- Flush: flush with 3 valid entries and out_valid=1 while in_valid=1 -> count=0 and out_valid=0 after the edge; the incoming instruction is not stored. Assert reset between edges -> outputs reach reset values immediately.

Source files
------------

// File: rtl/reservation_station_nw_pkg.sv
// rtl/reservation_station_nw_pkg.sv - shared types for the ALU reservation station
package reservation_station_nw_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 6;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } ALU_FUNC;

    // Depth-independent part of an entry; the station appends its own age field.
    typedef struct packed {
        logic                   valid;
        ALU_FUNC                func;
        logic [ROB_TAG_LEN-1:0] t1;
        logic [ROB_TAG_LEN-1:0] t2;
        logic [ROB_TAG_LEN-1:0] dst;
        logic                   rdy1;
        logic                   rdy2;
        logic [XLEN-1:0]        v1;
        logic [XLEN-1:0]        v2;
    } RS_ENTRY_NW;

endpackage

// File: rtl/reservation_station_nw_if.sv
// rtl/reservation_station_nw_if.sv - dispatch, CDB, issue and status bundle of the station
interface reservation_station_nw_if #(
    parameter int NUM_CDB = 2,
    parameter int AGE_W   = 3
) ();
    import reservation_station_nw_pkg::*;

    logic                                    in_valid;
    logic                                    in_ready;
    ALU_FUNC                                 in_func;
    logic [ROB_TAG_LEN-1:0]                  in_t1;
    logic [ROB_TAG_LEN-1:0]                  in_t2;
    logic [ROB_TAG_LEN-1:0]                  in_dst;
    logic                                    in_rdy1;
    logic                                    in_rdy2;
    logic [XLEN-1:0]                         in_v1;
    logic [XLEN-1:0]                         in_v2;

    logic [NUM_CDB-1:0]                      cdb_valid;
    logic [NUM_CDB-1:0][ROB_TAG_LEN-1:0]     cdb_tag;
    logic [NUM_CDB-1:0][XLEN-1:0]            cdb_value;

    logic                                    out_valid;
    logic                                    out_ready;
    ALU_FUNC                                 out_func;
    logic [XLEN-1:0]                         out_v1;
    logic [XLEN-1:0]                         out_v2;
    logic [ROB_TAG_LEN-1:0]                  out_dst;

    logic [AGE_W:0]                          count;
    logic                                    full;
    logic                                    empty;

    modport master (
        output in_valid, in_func, in_t1, in_t2, in_dst, in_rdy1, in_rdy2, in_v1, in_v2,
        output cdb_valid, cdb_tag, cdb_value, out_ready,
        input  in_ready, out_valid, out_func, out_v1, out_v2, out_dst, count, full, empty
    );

    modport slave (
        input  in_valid, in_func, in_t1, in_t2, in_dst, in_rdy1, in_rdy2, in_v1, in_v2,
        input  cdb_valid, cdb_tag, cdb_value, out_ready,
        output in_ready, out_valid, out_func, out_v1, out_v2, out_dst, count, full, empty
    );

endinterface

// File: rtl/reservation_station_nw_rs_age_select.sv
// rtl/reservation_station_nw_rs_age_select.sv - combinational oldest-ready entry finder
module rs_age_select #(
    parameter int NUM_ENTRIES = 8,
    parameter int AGE_W       = 3
) (
    input  logic [NUM_ENTRIES-1:0]            ready,
    input  logic [NUM_ENTRIES-1:0][AGE_W-1:0] age,
    output logic [AGE_W-1:0]                  sel,
    output logic                              found
);

    logic [AGE_W-1:0] best_age;

    // Valid ages are unique, so strict less-than never needs a tie-break.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        best_age = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ready[i] && (!found || (age[i] < best_age))) begin
                sel      = AGE_W'(i);
                found    = 1'b1;
                best_age = age[i];
            end
        end
    end

endmodule

// File: rtl/reservation_station_nw.sv
// rtl/reservation_station_nw.sv - age-ordered ALU reservation station; RS_BYPASS_EN enables same-cycle CDB issue
module reservation_station_nw
    import reservation_station_nw_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_CDB     = 2,
    parameter int AGE_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    reservation_station_nw_if.slave  bus
);

    typedef struct packed {
        RS_ENTRY_NW       body;
        logic [AGE_W-1:0] age;
    } rs_slot_t;

    rs_slot_t                            slot_q [NUM_ENTRIES];
    logic [AGE_W:0]                      count_q;
    logic                                out_valid_q;
    ALU_FUNC                             out_func_q;
    logic [XLEN-1:0]                     out_v1_q;
    logic [XLEN-1:0]                     out_v2_q;
    logic [ROB_TAG_LEN-1:0]              out_dst_q;

    logic [NUM_ENTRIES-1:0]              wake1;
    logic [NUM_ENTRIES-1:0]              wake2;
    logic [NUM_ENTRIES-1:0][XLEN-1:0]    wval1;
    logic [NUM_ENTRIES-1:0][XLEN-1:0]    wval2;
    logic [NUM_ENTRIES-1:0]              ready_vec;
    logic [NUM_ENTRIES-1:0][AGE_W-1:0]   age_vec;

    logic [AGE_W-1:0]                    sel_idx;
    logic                                sel_found;
    logic                                issue;
    logic [XLEN-1:0]                     iss_v1;
    logic [XLEN-1:0]                     iss_v2;

    logic                                full_w;
    logic                                load;
    logic [AGE_W-1:0]                    free_idx;
    RS_ENTRY_NW                          ld_entry;
    logic                                ld_hit1;
    logic                                ld_hit2;
    logic [XLEN-1:0]                     ld_val1;
    logic [XLEN-1:0]                     ld_val2;

    // Lowest-index matching port wins: scan downwards so the last write is port 0.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [ROB_TAG_LEN-1:0]              tag,
        input logic [NUM_CDB-1:0]                  cv,
        input logic [NUM_CDB-1:0][ROB_TAG_LEN-1:0] ct,
        input logic [NUM_CDB-1:0][XLEN-1:0]        cval
    );
        logic [XLEN:0] res;
        res = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (cv[p] && (ct[p] == tag)) res = {1'b1, cval[p]};
        end
        return res;
    endfunction

    always_comb begin
        wake1     = '0;
        wake2     = '0;
        wval1     = '0;
        wval2     = '0;
        ready_vec = '0;
        age_vec   = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            {wake1[e], wval1[e]} = cdb_lookup(slot_q[e].body.t1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            {wake2[e], wval2[e]} = cdb_lookup(slot_q[e].body.t2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            age_vec[e] = slot_q[e].age;
`ifdef RS_BYPASS_EN
            ready_vec[e] = slot_q[e].body.valid
                         && (slot_q[e].body.rdy1 || wake1[e])
                         && (slot_q[e].body.rdy2 || wake2[e]);
`else
            ready_vec[e] = slot_q[e].body.valid && slot_q[e].body.rdy1 && slot_q[e].body.rdy2;
`endif
        end
    end

    rs_age_select #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .AGE_W       (AGE_W)
    ) u_age_select (
        .ready (ready_vec),
        .age   (age_vec),
        .sel   (sel_idx),
        .found (sel_found)
    );

    assign issue  = sel_found && (!out_valid_q || bus.out_ready);
    assign iss_v1 = slot_q[sel_idx].body.rdy1 ? slot_q[sel_idx].body.v1 : wval1[sel_idx];
    assign iss_v2 = slot_q[sel_idx].body.rdy2 ? slot_q[sel_idx].body.v2 : wval2[sel_idx];

    assign full_w = (count_q == (AGE_W+1)'(NUM_ENTRIES));
    assign load   = bus.in_valid && !full_w;

    always_comb begin
        free_idx = '0;
        for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
            if (!slot_q[e].body.valid) free_idx = AGE_W'(e);
        end
    end

    // Operands not yet ready may still be captured from the CDB on the load edge.
    always_comb begin
        {ld_hit1, ld_val1} = cdb_lookup(bus.in_t1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        {ld_hit2, ld_val2} = cdb_lookup(bus.in_t2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        ld_entry       = '0;
        ld_entry.valid = 1'b1;
        ld_entry.func  = bus.in_func;
        ld_entry.t1    = bus.in_t1;
        ld_entry.t2    = bus.in_t2;
        ld_entry.dst   = bus.in_dst;
        ld_entry.rdy1  = bus.in_rdy1 || ld_hit1;
        ld_entry.rdy2  = bus.in_rdy2 || ld_hit2;
        ld_entry.v1    = bus.in_rdy1 ? bus.in_v1 : ld_val1;
        ld_entry.v2    = bus.in_rdy2 ? bus.in_v2 : ld_val2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < NUM_ENTRIES; e++) slot_q[e] <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_func_q  <= ALU_ADD;
            out_v1_q    <= '0;
            out_v2_q    <= '0;
            out_dst_q   <= '0;
        end else if (flush) begin
            for (int e = 0; e < NUM_ENTRIES; e++) slot_q[e].body.valid <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (slot_q[e].body.valid) begin
                    if (!slot_q[e].body.rdy1 && wake1[e]) begin
                        slot_q[e].body.rdy1 <= 1'b1;
                        slot_q[e].body.v1   <= wval1[e];
                    end
                    if (!slot_q[e].body.rdy2 && wake2[e]) begin
                        slot_q[e].body.rdy2 <= 1'b1;
                        slot_q[e].body.v2   <= wval2[e];
                    end
                    if (issue && (slot_q[e].age > slot_q[sel_idx].age))
                        slot_q[e].age <= slot_q[e].age - 1'b1;
                end
            end
            if (issue) slot_q[sel_idx].body.valid <= 1'b0;
            if (load) begin
                slot_q[free_idx].body <= ld_entry;
                slot_q[free_idx].age  <= AGE_W'(count_q - (AGE_W+1)'(issue));
            end
            count_q <= count_q + (AGE_W+1)'(load) - (AGE_W+1)'(issue);

            if (issue) begin
                out_valid_q <= 1'b1;
                out_func_q  <= slot_q[sel_idx].body.func;
                out_v1_q    <= iss_v1;
                out_v2_q    <= iss_v2;
                out_dst_q   <= slot_q[sel_idx].body.dst;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = !full_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_func  = out_func_q;
    assign bus.out_v1    = out_v1_q;
    assign bus.out_v2    = out_v2_q;
    assign bus.out_dst   = out_dst_q;
    assign bus.count     = count_q;
    assign bus.full      = full_w;
    assign bus.empty     = (count_q == '0);

endmodule
